// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, default timeout, ring helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    localparam int TMO_CYC_DEF = 6000;

    // Slot reached by stepping 'step' places past 'base' around a ring of n slots.
    function automatic int rr_wrap(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority picker: the first active request after last_grant wins.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
)(
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int GW = $clog2(N_REQ);

    logic [GW-1:0] cand;

    // Walk from the farthest slot back toward last_grant+1 so the nearest requester is assigned last.
    always_comb begin
        idx  = '0;
        cand = '0;
        for (int s = N_REQ; s >= 1; s--) begin
            cand = GW'(rr_wrap(int'(last_grant), s, N_REQ));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// Define UART_ARB_PKT_LOCK_EN to hold the grant across a packet until its last byte.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TMO_CYC = TMO_CYC_DEF
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     tmo_err
);

    localparam int            GW       = $clog2(N_REQ);
    localparam int            CW       = $clog2(TMO_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYC - 1);

    arb_state_t    state, state_n;
    logic [GW-1:0] grant_q, grant_n;
    logic [GW-1:0] last_grant, last_grant_n;
    logic [GW-1:0] pick_idx;
    logic          pick_valid;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    data_q, data_n;
    logic [7:0]    cur_data;
    logic          cur_req;

`ifdef UART_ARB_PKT_LOCK_EN
    logic last_q, last_n;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign cur_req = req[grant_q];

    always_comb begin
        cur_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                cur_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= GW'(N_REQ - 1);
            cnt        <= '0;
            data_q     <= 8'h00;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
            data_q     <= data_n;
`ifdef UART_ARB_PKT_LOCK_EN
            last_q     <= last_n;
`endif
        end
    end

    // tx_done outranks the timeout in WAIT, so a byte finishing on the final count is not flagged.
    always_comb begin
        state_n      = state;
        grant_n      = grant_q;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        data_n       = data_q;
        req_ack      = '0;
        tx_start     = 1'b0;
        tmo_err      = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
        last_n       = last_q;
`endif
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_n = pick_idx;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cur_req) begin
                    tx_start         = 1'b1;
                    req_ack[grant_q] = 1'b1;
                    data_n           = cur_data;
                    cnt_n            = '0;
                    state_n          = ST_WAIT;
`ifdef UART_ARB_PKT_LOCK_EN
                    last_n           = req_last[grant_q];
`endif
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    last_grant_n = grant_q;
                    state_n      = ST_IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
                    if (!last_q) begin
                        state_n = ST_SEND;
                    end
`endif
                end else if (cnt == CNT_LAST) begin
                    tmo_err      = 1'b1;
                    last_grant_n = grant_q;
                    state_n      = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // The byte is presented alongside its start pulse, then held from the register.
    assign tx_data  = tx_start ? cur_data : data_q;
    assign grant_id = grant_q;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: requester and transmitter models drive the DUT,
// expected grants, bytes and start cycles are queued when stimulus is loaded and compared against observed starts.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int N   = 4;
    localparam int TMO = 200;
    localparam int DLY = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           busy;
    logic           tmo_err;

    uart_tx_arb #(.N_REQ(N), .TMO_CYC(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy),
        .tmo_err  (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [7:0] data; int cyc; } exp_t;
    typedef struct { int cyc; logic [N-1:0] ack; logic [7:0] data; logic [1:0] grant; } obs_t;

    exp_t       exp_q[$];
    obs_t       obs_q[$];
    int         tmo_q[$];
    logic       busy_log [0:1023];
    logic [7:0] src_data [N][8];
    logic       src_last [N][8];
    int         src_len [N];
    int         src_pos [N];
    int         timer;
    bit         tx_en;
    int         done_dly;
    int         proto_err;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        timer = 0; tx_en = 1'b0; done_dly = DLY; proto_err = 0;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete(); obs_q.delete(); tmo_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_byte(input int id, input logic [7:0] data, input logic last);
        src_data[id][src_len[id]] = data;
        src_last[id][src_len[id]] = last;
        src_len[id]++;
    endtask

    task automatic push_exp(input int id, input logic [7:0] data, input int cyc);
        exp_q.push_back('{id: id, data: data, cyc: cyc});
    endtask

    // Requesters hold each byte until acked; the transmitter model answers DLY cycles after a start.
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (src_pos[i] < src_len[i]) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = src_data[i][src_pos[i]];
                    req_last[i] = src_last[i][src_pos[i]];
                end else begin
                    req[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
            tx_done = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) tx_done = 1'b1;
            end
            @(negedge clk);
            if (c < 1024) busy_log[c] = busy;
            if (req_ack !== '0 && tx_start !== 1'b1) proto_err++;
            if ($countones(req_ack) > 1) proto_err++;
            if (tmo_err === 1'b1) tmo_q.push_back(c);
            if (tx_start === 1'b1) begin
                obs_q.push_back('{cyc: c, ack: req_ack, data: tx_data, grant: grant_id});
                for (int i = 0; i < N; i++) begin
                    if (req_ack[i] === 1'b1) src_pos[i]++;
                end
                if (tx_en) timer = done_dly;
            end
        end
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++; if (req_ack !== '0)    begin n_fail++; $display("[TB] FAIL reset_ack: got %b, expected 0000", req_ack); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_start: got %b, expected 0", tx_start); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h, expected 00", tx_data); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_grant: got %0d, expected 0", grant_id); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (tmo_err !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_tmo: got %b, expected 0", tmo_err); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        obs_t o;
        logic [N-1:0] ea;
        do_reset();
        tx_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                load_byte(i, 8'h41 + 8'(i), 1'b1);
                push_exp(i, 8'h41 + 8'(i), 1 + 22 * (k * N + i));
            end
        end
        run_cycles(200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ea = '0; ea[e.id] = 1'b1;
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("[TB] FAIL rr_missing: no start seen, expected data %h from req %0d", e.data, e.id);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.ack !== ea || o.grant !== 2'(e.id) || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL rr_byte: got data %h ack %b grant %0d cyc %0d, expected data %h ack %b grant %0d cyc %0d",
                             o.data, o.ack, o.grant, o.cyc, e.data, ea, e.id, e.cyc);
                end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL rr_extra: %0d extra starts, expected 0", obs_q.size()); end
        n_checks++; if (proto_err != 0) begin n_fail++; $display("[TB] FAIL rr_proto: %0d ack violations, expected 0", proto_err); end
    endtask

    task automatic test_timeout();
        exp_t e;
        obs_t o;
        do_reset();
        load_byte(2, 8'h55, 1'b1);
        load_byte(2, 8'h55, 1'b1);
        push_exp(2, 8'h55, 1);
        push_exp(2, 8'h55, TMO + 3);
        run_cycles(2 * TMO + 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("[TB] FAIL tmo_missing: no start seen, expected start at cyc %0d", e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.ack !== 4'b0100 || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL tmo_byte: got data %h ack %b cyc %0d, expected data %h ack 0100 cyc %0d",
                             o.data, o.ack, o.cyc, e.data, e.cyc);
                end
            end
        end
        n_checks++;
        if (tmo_q.size() != 2) begin
            n_fail++; $display("[TB] FAIL tmo_count: got %0d pulses, expected 2", tmo_q.size());
        end else if (tmo_q[0] != 1 + TMO || tmo_q[1] != 2 * TMO + 3) begin
            n_fail++; $display("[TB] FAIL tmo_cycle: got %0d/%0d, expected %0d/%0d", tmo_q[0], tmo_q[1], 1 + TMO, 2 * TMO + 3);
        end
        n_checks++; if (busy_log[TMO + 2] !== 1'b0) begin n_fail++; $display("[TB] FAIL tmo_busy: got %b after timeout, expected 0", busy_log[TMO + 2]); end
        n_checks++; if (proto_err != 0) begin n_fail++; $display("[TB] FAIL tmo_proto: %0d ack violations, expected 0", proto_err); end
    endtask

    task automatic test_done_vs_tmo();
        do_reset();
        tx_en = 1'b1;
        done_dly = TMO;
        load_byte(0, 8'h77, 1'b1);
        run_cycles(TMO + 10);
        n_checks++; if (tmo_q.size() != 0) begin n_fail++; $display("[TB] FAIL race_tmo: got %0d pulses, expected 0", tmo_q.size()); end
        n_checks++; if (busy_log[TMO + 1] !== 1'b1 || busy_log[TMO + 2] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL race_busy: got %b%b, expected 10", busy_log[TMO + 1], busy_log[TMO + 2]);
        end
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("[TB] FAIL race_starts: got %0d, expected 1", obs_q.size()); end
    endtask

    task automatic test_withdraw();
        exp_t e;
        obs_t o;
        logic [N-1:0] ea;
        do_reset();
        @(posedge clk); #1;
        req = 4'b0010; req_data = {4{8'h61}};
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_idle: got busy %b start %b, expected 0 0", busy, tx_start); end
        @(posedge clk); #1;
        req = '0; req_data = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || tx_start !== 1'b0 || req_ack !== '0) begin
            n_fail++; $display("[TB] FAIL wd_send: got busy %b start %b ack %b, expected 1 0 0000", busy, tx_start, req_ack);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0 || req_ack !== '0) begin
                n_fail++; $display("[TB] FAIL wd_after: got busy %b start %b ack %b, expected 0 0 0000", busy, tx_start, req_ack);
            end
        end
        // A withdrawn grant must not advance the rotation: req1 still precedes req3.
        tx_en = 1'b1;
        load_byte(1, 8'h61, 1'b1);
        load_byte(3, 8'h63, 1'b1);
        push_exp(1, 8'h61, 1);
        push_exp(3, 8'h63, 23);
        run_cycles(60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ea = '0; ea[e.id] = 1'b1;
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("[TB] FAIL wd_missing: no start seen, expected req %0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.ack !== ea || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL wd_byte: got data %h ack %b cyc %0d, expected data %h ack %b cyc %0d",
                             o.data, o.ack, o.cyc, e.data, ea, e.cyc);
                end
            end
        end
        n_checks++; if (proto_err != 0) begin n_fail++; $display("[TB] FAIL wd_proto: %0d ack violations, expected 0", proto_err); end
    endtask

    task automatic test_pkt_lock();
        exp_t e;
        obs_t o;
        logic [N-1:0] ea;
        do_reset();
        tx_en = 1'b1;
        load_byte(0, 8'hA0, 1'b0);
        load_byte(0, 8'hA1, 1'b0);
        load_byte(0, 8'hA2, 1'b1);
        load_byte(1, 8'hB0, 1'b1);
        load_byte(1, 8'hB1, 1'b1);
`ifdef UART_ARB_PKT_LOCK_EN
        push_exp(0, 8'hA0, 1);  push_exp(0, 8'hA1, 22); push_exp(0, 8'hA2, 43);
        push_exp(1, 8'hB0, 65); push_exp(1, 8'hB1, 87);
`else
        push_exp(0, 8'hA0, 1);  push_exp(1, 8'hB0, 23); push_exp(0, 8'hA1, 45);
        push_exp(1, 8'hB1, 67); push_exp(0, 8'hA2, 89);
`endif
        run_cycles(120);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ea = '0; ea[e.id] = 1'b1;
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("[TB] FAIL pkt_missing: no start seen, expected data %h", e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.data !== e.data || o.ack !== ea || o.grant !== 2'(e.id) || o.cyc != e.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL pkt_byte: got data %h ack %b grant %0d cyc %0d, expected data %h ack %b grant %0d cyc %0d",
                             o.data, o.ack, o.grant, o.cyc, e.data, ea, e.id, e.cyc);
                end
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL pkt_extra: %0d extra starts, expected 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        load_byte(2, 8'h99, 1'b1);
        run_cycles(5);
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("[TB] FAIL rw_start: got %0d starts, expected 1", obs_q.size()); end
        @(posedge clk); #1;
        rst = 1'b1; src_len[2] = 0; req = '0; req_data = '0; req_last = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            tx_done = (k == 1);
            @(negedge clk);
            n_checks++;
            if (tx_start !== 1'b0 || req_ack !== '0 || tmo_err !== 1'b0 || busy !== 1'b0 ||
                grant_id !== 2'd0 || tx_data !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL rw_outputs: got start %b ack %b tmo %b busy %b grant %0d data %h, expected 0 0000 0 0 0 00",
                         tx_start, req_ack, tmo_err, busy, grant_id, tx_data);
            end
        end
        tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_timeout();
        test_done_vs_tmo();
        test_withdraw();
        test_pkt_lock();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
